rr_collect: RTL and testbench
=============================

Name: rr_collect

Overview:
- Downstream stage of the demux. Consumes its NUMIN-lane vector (`dout_vec` / `dout_vec_v`) and merges the lanes back into a single serial stream.
- Each lane has a one-entry holding register, so lanes need no backpressure.
- A round-robin arbiter drains full lanes into one registered output with a valid/ready handshake. The output carries the lane index.
- Lanes that are hit again while still full are flagged as overflow.

Parameters:
- NUMIN, 16: number of input lanes; must match the demux NUMOUT.
- DWIDTH, 14: data width per lane.
- SWIDTH, $clog2(NUMIN): lane index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- din_vec  in  NUMIN*DWIDTH  lane data; lane i is at din_vec[i*DWIDTH +: DWIDTH].
- din_vec_v  in  NUMIN  per-lane valid; a single-cycle strobe per word.
- dout  out  DWIDTH  merged data word.
- dout_sel  out  SWIDTH  lane index of dout.
- dout_v  out  1  dout/dout_sel valid.
- dout_rdy  in  1  downstream accepts when dout_v && dout_rdy at a rising edge.
- ovf  out  NUMIN  sticky per-lane overflow flags.
- ovf_clr  in  1  clears all ovf bits.

Behaviour:
- Reset (async assert, sync release): all lane full flags=0, lane data=0, dout=0, dout_sel=0, dout_v=0, ovf=0, rr pointer=0. Reset mid-stream discards all held words; nothing is emitted after release until new input arrives.
- Lane capture: din_vec_v[i]=1 at an edge with lane i empty or being drained that edge -> lane i data loaded and full[i]=1.
- Overflow: din_vec_v[i]=1 with lane i full and not drained that edge -> new word dropped, old word kept, ovf[i] set.
- Drain + capture same edge: new word accepted, full[i] stays 1, no overflow.
- Output stage load condition: out_free = !dout_v || dout_rdy.
- Grant: when out_free and any full[i], grant the first full lane searching ptr, ptr+1, ... NUMIN-1, 0, ... ptr-1.
  - At the edge: dout=lane data, dout_sel=grant, dout_v=1, full[grant] cleared (unless recaptured per the rule above), ptr=grant+1 with wrap to 0 after NUMIN-1.
- No full lane and out_free -> dout_v=0 next edge; dout/dout_sel hold their last values.
- dout_v && !dout_rdy -> dout, dout_sel and dout_v hold stable; no grant; ptr unchanged.
- Latency: din_vec_v sampled at edge k -> full at k -> dout_v at earliest after edge k+1 (2 edges). Sustained throughput is 1 word/cycle with dout_rdy=1.
- Fairness: with all NUMIN lanes continuously full, each lane is granted exactly once per NUMIN accepted words.
- ovf_clr=1 clears all ovf bits at the edge. An overflow event on the same edge wins: that bit reads 1.
- Ordering is preserved within a lane only; no ordering guarantee across lanes.
- The one-hot demux source raises at most one din_vec_v bit per cycle. The block still handles any number of simultaneous lane valids.
- Implementation style: the arbiter is combinational rotate/priority-find; all outputs are registered.

Optional Feature:
- Macro: RR_COLLECT_DROP_CNT_EN.
- Defined: adds output port drop_cnt [15:0].
  - Counts every dropped word in a cycle: +k when k lanes overflow that edge.
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared by ovf_clr (increments on the same edge are lost).
- Undefined: port and counter absent; everything else identical.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles with random din_vec_v -> dout_v=0, ovf=0, dout=0. Assert rst_n low mid-burst -> dout_v drops immediately (async) and stays 0 after release with no input.
- Single word: dout_rdy=1; lane 5 strobed with 14'h0123 at edge k -> dout=14'h0123, dout_sel=5, dout_v=1 after edge k+1 for one cycle.
- Demux sweep: drive lanes 0..15 sequentially with data 0..15, one per cycle, dout_rdy=1 -> 16 outputs in order, dout_sel==dout, ovf=0.
- Round-robin and wrap: preload lanes 3, 9 and 15 with dout_rdy=0. Release, then strobe lane 3 again -> order 3, 9, 15, 3; ptr wraps past 15.
- Backpressure/overflow: dout_rdy=0, strobe lane 2 twice with 14'h0AAA then 14'h0BBB -> ovf[2]=1 and dout holds stable. Raise dout_rdy -> 14'h0AAA emitted once. ovf_clr -> ovf=0. With macro defined, drop_cnt=1 before the clear and 0 after.
- Drain+capture: lane 7 full and granted on the same edge as a new strobe 14'h0042 -> no ovf; 14'h0042 emitted next grant of lane 7.

Source files
------------

// File: rtl/rr_collect_if.sv
// rr_collect lane-vector input and serial output bundle.
// slave is the collector view; master is the driver/sink view.
interface rr_collect_if #(
  parameter int NUMIN  = 16,
  parameter int DWIDTH = 14,
  parameter int SWIDTH = $clog2(NUMIN)
);
  logic [NUMIN*DWIDTH-1:0] din_vec;
  logic [NUMIN-1:0]        din_vec_v;
  logic [DWIDTH-1:0]       dout;
  logic [SWIDTH-1:0]       dout_sel;
  logic                    dout_v;
  logic                    dout_rdy;

  modport master (
    output din_vec, din_vec_v, dout_rdy,
    input  dout, dout_sel, dout_v
  );

  modport slave (
    input  din_vec, din_vec_v, dout_rdy,
    output dout, dout_sel, dout_v
  );
endinterface

// File: rtl/rr_collect.sv
// Round-robin lane collector: one holding slot per lane, registered output.
// Define RR_COLLECT_DROP_CNT_EN to add the saturating drop_cnt port.
module rr_collect #(
  parameter int NUMIN  = 16,
  parameter int DWIDTH = 14,
  parameter int SWIDTH = $clog2(NUMIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_collect_if.slave      bus,
  output logic [NUMIN-1:0] ovf,
  input  logic             ovf_clr
`ifdef RR_COLLECT_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  logic [NUMIN-1:0]             full_q, full_d;
  logic [NUMIN-1:0][DWIDTH-1:0] data_q, data_d;
  logic [SWIDTH-1:0]            ptr_q, ptr_d;
  logic [SWIDTH-1:0]            sel_q, sel_d;
  logic [DWIDTH-1:0]            dout_q, dout_d;
  logic                         dv_q, dv_d;
  logic [NUMIN-1:0]             ovf_q, ovf_d;

  logic              out_free;
  logic              gnt_v;
  logic [SWIDTH-1:0] gnt;
  logic [SWIDTH-1:0] off;
  logic [SWIDTH:0]   lsh;
  logic [SWIDTH:0]   gsum;
  logic [NUMIN-1:0]  rot;
  logic [NUMIN-1:0]  drain;
  logic [NUMIN-1:0]  load;
  logic [NUMIN-1:0]  hit;

  // Rotate so bit 0 is the pointer lane, then take the lowest set bit.
  always_comb begin
    out_free = !dv_q || bus.dout_rdy;
    lsh  = (SWIDTH+1)'(NUMIN) - {1'b0, ptr_q};
    rot  = (full_q >> ptr_q) | (full_q << lsh);
    off  = '0;
    for (int k = NUMIN-1; k >= 0; k--) begin
      if (rot[k]) off = SWIDTH'(k);
    end
    gsum = {1'b0, ptr_q} + {1'b0, off};
    if (gsum >= (SWIDTH+1)'(NUMIN))
      gsum = gsum - (SWIDTH+1)'(NUMIN);
    gnt   = gsum[SWIDTH-1:0];
    gnt_v = out_free && (|full_q);
  end

  always_comb begin
    drain  = '0;
    load   = '0;
    hit    = '0;
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < NUMIN; i++) begin
      drain[i] = gnt_v && (gnt == SWIDTH'(i));
      load[i]  = bus.din_vec_v[i]
               && (!full_q[i] || drain[i]);
      hit[i]   = bus.din_vec_v[i]
               && full_q[i] && !drain[i];
      full_d[i] = load[i]
                | (full_q[i] & ~drain[i]);
      if (load[i])
        data_d[i] = bus.din_vec[i*DWIDTH +: DWIDTH];
    end
    ovf_d = (ovf_clr ? '0 : ovf_q) | hit;
  end

  always_comb begin
    dout_d = dout_q;
    sel_d  = sel_q;
    dv_d   = dv_q;
    ptr_d  = ptr_q;
    if (out_free) begin
      dv_d = gnt_v;
      if (gnt_v) begin
        dout_d = data_q[gnt];
        sel_d  = gnt;
        if (gnt == SWIDTH'(NUMIN-1))
          ptr_d = '0;
        else
          ptr_d = gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      sel_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_sel = sel_q;
  assign bus.dout_v   = dv_q;
  assign ovf          = ovf_q;

`ifdef RR_COLLECT_DROP_CNT_EN
  logic [15:0]     drop_q, drop_d;
  logic [SWIDTH:0] nhit;
  logic [16:0]     dsum;

  always_comb begin
    nhit = '0;
    for (int i = 0; i < NUMIN; i++)
      nhit = nhit + (SWIDTH+1)'(hit[i]);
    dsum = {1'b0, drop_q} + 17'(nhit);
    if (ovf_clr)
      drop_d = '0;
    else if (dsum[16])
      drop_d = 16'hFFFF;
    else
      drop_d = dsum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_rr_collect.sv
// Randomized bench for rr_collect with a lane/queue reference model.
// Directed cases pin the model with hand-computed literals.
module tb_rr_collect;
  localparam int N = 16;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] ovf;
`ifdef RR_COLLECT_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  rr_collect_if #(.NUMIN(N), .DWIDTH(W)) bus();

  rr_collect #(.NUMIN(N), .DWIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef RR_COLLECT_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_full[N];
  logic [W-1:0] m_data[N];
  int           m_ptr;
  bit           m_dv;
  logic [W-1:0] m_dout;
  int           m_sel;
  logic [N-1:0] m_ovf;
  int           m_drop;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0;
      m_data[i] = '0;
    end
    m_ptr = 0; m_dv = 0; m_dout = '0;
    m_sel = 0; m_ovf = '0; m_drop = 0;
  endtask

  task automatic m_step();
    bit           free;
    int           g;
    int           hits;
    logic [W-1:0] od;
    logic [N-1:0] nov;
    free = !m_dv || bus.dout_rdy;
    g = -1;
    od = '0;
    if (free)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_full[(m_ptr + k) % N])
          g = (m_ptr + k) % N;
    if (g >= 0) od = m_data[g];
    hits = 0;
    nov = ovf_clr ? '0 : m_ovf;
    for (int i = 0; i < N; i++) begin
      if (bus.din_vec_v[i]) begin
        if (m_full[i] && g != i) begin
          hits++;
          nov[i] = 1'b1;
        end else begin
          m_full[i] = 1;
          m_data[i] = bus.din_vec[i*W +: W];
        end
      end else if (g == i) begin
        m_full[i] = 0;
      end
    end
    m_ovf = nov;
    if (ovf_clr) m_drop = 0;
    else m_drop = (m_drop + hits > 65535) ? 65535 : m_drop + hits;
    if (free) begin
      if (g >= 0) begin
        m_dout = od; m_sel = g; m_dv = 1;
        m_ptr = (g + 1) % N;
      end else begin
        m_dv = 0;
      end
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    chk("m_dout_v", bus.dout_v, m_dv);
    if (m_dv) begin
      chk("m_dout", bus.dout, m_dout);
      chk("m_dout_sel", bus.dout_sel, m_sel);
    end
    chk("m_ovf", ovf, m_ovf);
`ifdef RR_COLLECT_DROP_CNT_EN
    chk("m_drop_cnt", drop_cnt, m_drop);
`endif
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N*W-1:0] put(int i, logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N-1:0] bitn(int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic cyc(input logic [N-1:0] v,
                     input logic [N*W-1:0] d,
                     input bit rdy, input bit clr);
    @(negedge clk);
    bus.din_vec_v = v;
    bus.din_vec   = d;
    bus.dout_rdy  = rdy;
    ovf_clr       = clr;
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  initial begin
    int e;
    int exp_sel[4];
    int exp_dat[4];
    logic [N-1:0] v;
    int r;

    bus.din_vec_v = '0;
    bus.din_vec   = '0;
    bus.dout_rdy  = 1'b0;

    // reset with random traffic
    repeat (10) cyc(N'($urandom), rand_data(), 1'b1, 1'b0);
    chk("rst_dout_v", bus.dout_v, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", bus.dout, 0);
    cyc('0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, '0, 1'b1, 1'b0);
    chk("post_rst_idle", bus.dout_v, 0);

    // single word, lane 5
    cyc(bitn(5), put(5, 14'h0123), 1'b1, 1'b0);
    cyc('0, '0, 1'b1, 1'b0);
    chk("single_early", bus.dout_v, 0);
    cyc('0, '0, 1'b1, 1'b0);
    chk("single_v", bus.dout_v, 1);
    chk("single_dout", bus.dout, 14'h0123);
    chk("single_sel", bus.dout_sel, 5);
    cyc('0, '0, 1'b1, 1'b0);
    chk("single_once", bus.dout_v, 0);

    // demux sweep
    e = 0;
    for (int i = 0; i < N + 3; i++) begin
      if (i < N) cyc(bitn(i), put(i, W'(i)), 1'b1, 1'b0);
      else cyc('0, '0, 1'b1, 1'b0);
      if (bus.dout_v) begin
        chk("sweep_dout", bus.dout, e);
        chk("sweep_sel", bus.dout_sel, e);
        e++;
      end
    end
    chk("sweep_cnt", e, 16);
    chk("sweep_ovf", ovf, 0);

    // round robin and pointer wrap
    cyc(bitn(3) | bitn(9) | bitn(15),
        put(3, 14'h0300) | put(9, 14'h0900) | put(15, 14'h0F00),
        1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("rr_first", bus.dout_sel, 3);
    cyc('0, '0, 1'b0, 1'b0);
    chk("rr_hold_v", bus.dout_v, 1);
    chk("rr_hold", bus.dout, 14'h0300);
    exp_sel = '{3, 9, 15, 3};
    exp_dat = '{14'h0300, 14'h0900, 14'h0F00, 14'h0333};
    for (int s = 0; s < 4; s++) begin
      if (s == 0) cyc(bitn(3), put(3, 14'h0333), 1'b1, 1'b0);
      else cyc('0, '0, 1'b1, 1'b0);
      chk("rr_v", bus.dout_v, 1);
      chk("rr_sel", bus.dout_sel, exp_sel[s]);
      chk("rr_dout", bus.dout, exp_dat[s]);
    end
    cyc('0, '0, 1'b1, 1'b0);
    chk("rr_done", bus.dout_v, 0);

    // backpressure and overflow
    cyc(bitn(0), put(0, 14'h0111), 1'b0, 1'b0);
    cyc(bitn(2), put(2, 14'h0AAA), 1'b0, 1'b0);
    cyc(bitn(2), put(2, 14'h0BBB), 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("bp_ovf", ovf, 16'h0004);
    chk("bp_hold", bus.dout, 14'h0111);
`ifdef RR_COLLECT_DROP_CNT_EN
    chk("bp_drop1", drop_cnt, 1);
`endif
    cyc('0, '0, 1'b1, 1'b0);
    chk("bp_hold2", bus.dout, 14'h0111);
    cyc('0, '0, 1'b1, 1'b0);
    chk("bp_aaa", bus.dout, 14'h0AAA);
    chk("bp_aaa_sel", bus.dout_sel, 2);
    cyc('0, '0, 1'b1, 1'b0);
    chk("bp_aaa_once", bus.dout_v, 0);
    chk("bp_ovf_sticky", ovf, 16'h0004);
    cyc('0, '0, 1'b1, 1'b1);
    cyc('0, '0, 1'b1, 1'b0);
    chk("bp_clr", ovf, 0);
`ifdef RR_COLLECT_DROP_CNT_EN
    chk("bp_drop0", drop_cnt, 0);
`endif

    // drain and capture on the same edge
    cyc(bitn(7), put(7, 14'h0007), 1'b1, 1'b0);
    cyc(bitn(7), put(7, 14'h0042), 1'b1, 1'b0);
    cyc('0, '0, 1'b1, 1'b0);
    chk("dc_first", bus.dout, 14'h0007);
    cyc('0, '0, 1'b1, 1'b0);
    chk("dc_second", bus.dout, 14'h0042);
    chk("dc_sel", bus.dout_sel, 7);
    chk("dc_ovf", ovf, 0);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      r = $urandom_range(0, 9);
      if (r < 5) v = bitn($urandom_range(0, N-1));
      else if (r < 7) v = '0;
      else v = N'($urandom);
      cyc(v, rand_data(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0);
    end

    // asynchronous reset mid-burst
    cyc('1, rand_data(), 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("pre_rst_v", bus.dout_v, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_v", bus.dout_v, 0);
    chk("async_rst_ovf", ovf, 0);
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, 1'b1, 1'b0);
      chk("post_rst_quiet", bus.dout_v, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
